// File: rtl/ndma_burst_write_mgr.sv
// NanoDMA write-path burst manager: takes one (addr, len) command, streams
// source beats onto OBI as writes, bounds in-flight writes to MAX_OUTST and
// reports completion and a sticky error for the command.
module ndma_burst_write_mgr #(
   parameter int DW        = 32,
   parameter int LEN_W     = 16,
   parameter int MAX_OUTST = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [31:0]      cmd_addr_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic             data_valid_i,
   output logic             data_ready_o,
   input  logic [DW-1:0]    data_i,
   output logic             obi_req_o,
   input  logic             obi_gnt_i,
   output logic [31:0]      obi_addr_o,
   output logic             obi_we_o,
   output logic [DW/8-1:0]  obi_be_o,
   output logic [DW-1:0]    obi_wdata_o,
   input  logic             obi_rvalid_i,
   input  logic             obi_err_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam int OW = $clog2(MAX_OUTST + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [OW-1:0]    outst_q, outst_d;
   logic             err_q, err_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] beats_q, beats_d;

   logic cmd_acc;
   logic wr_fire;
   logic rsp;

   assign cmd_acc = (state_q == S_IDLE) & cmd_valid_i;
   assign wr_fire = obi_req_o & obi_gnt_i;
   // Responses with nothing in flight (e.g. stragglers after a reset) are dropped.
   assign rsp     = obi_rvalid_i & (outst_q != '0);

   // In-flight write counter: +1 on grant, -1 on accepted response.
   always_comb begin
      outst_d = outst_q;
      if (wr_fire & ~rsp)
         outst_d = outst_q + OW'(1);
      else if (rsp & ~wr_fire)
         outst_d = outst_q - OW'(1);
   end

   // Command datapath: load on accept, advance address/count on each grant,
   // error sticks until the next command is taken.
   always_comb begin
      addr_d  = addr_q;
      beats_d = beats_q;
      err_d   = err_q;
      if (cmd_acc) begin
         addr_d  = cmd_addr_i;
         beats_d = cmd_len_i;
         err_d   = 1'b0;
      end else begin
         if (wr_fire) begin
            addr_d  = addr_q + 32'(DW/8);
            beats_d = beats_q - LEN_W'(1);
         end
         if (rsp & obi_err_i)
            err_d = 1'b1;
      end
   end

   // Datapath and counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outst_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         beats_q <= '0;
      end else begin
         outst_q <= outst_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: finish only once every granted write has been answered.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (cmd_valid_i)
               state_d = (cmd_len_i == '0) ? S_DONE : S_RUN;
         S_RUN:
            if (wr_fire && beats_q == LEN_W'(1))
               state_d = (outst_d == '0) ? S_DONE : S_DRAIN;
         S_DRAIN:
            if (outst_d == '0)
               state_d = S_DONE;
         S_DONE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request only with source data and a free in-flight slot,
   // so a request is never withdrawn before its grant.
   always_comb begin
      cmd_ready_o = (state_q == S_IDLE);
      obi_req_o   = (state_q == S_RUN) & data_valid_i & (outst_q < OW'(MAX_OUTST));
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE);
   end

   assign data_ready_o = wr_fire;
   assign obi_addr_o   = addr_q;
   assign obi_wdata_o  = data_i;
   assign obi_we_o     = 1'b1;
   assign obi_be_o     = '1;
   assign err_o        = err_q;

endmodule
